oct_sel_fsm: RTL and testbench
==============================

Name: oct_sel_fsm

Overview:
Parametrised octave selector, the successor to the single-button octave FSM. It takes two debounced and synchronised button levels (up/down) and keeps the current octave index in the range 0..NUM_OCT-1. Each button steps the index on a rising edge, with optional hold-to-repeat and a selectable wrap or saturate mode at the ends of the range. It drives the oscillator/note-decode path with the octave index, a one-cycle change strobe and range flags for the UI.

Parameters:
NUM_OCT, 7, number of octaves (legal 2..16); OW = $clog2(NUM_OCT)
DEF_OCT, 3, octave loaded at reset and on illegal-state recovery (must be < NUM_OCT)
WRAP, 1, 1 = wrap at ends; 0 = saturate at ends
REPEAT_EN, 0, 1 = enable hold-to-repeat stepping
HOLD_CYCLES, 16, cycles after the initial step before the first repeat step (>=1)
REP_CYCLES, 8, cycles between repeat steps (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
octave_up  input  1  up button level, already debounced and synchronised
octave_down  input  1  down button level, already debounced and synchronised
octave  output  OW  current octave index, registered
oct_changed  output  1  one-cycle pulse, high in the cycle after any edge that changed octave
at_min  output  1  octave == 0 (combinational from register)
at_max  output  1  octave == NUM_OCT-1 (combinational from register)

Behaviour:
- Reset is synchronous and active-high: on the clk edge with rst=1, octave=DEF_OCT, oct_changed=0, up_prev=down_prev=0, FSM=IDLE, and all counters=0. rst takes priority over every other input, including mid-repeat.
- Edge detect: up_rise = octave_up & ~up_prev (same for down). up_prev and down_prev register the inputs every cycle.
- Single press: on the clk edge where up_rise=1 and octave_down=0, octave steps +1. down_rise with octave_up=0 steps -1. Latency is one edge: the new value is visible right after that edge, and oct_changed is high for that one cycle.
- Both buttons high in the same cycle (either order, including simultaneous rises): no step. FSM goes to IDLE and counters clear.
- Range, WRAP=1: up at NUM_OCT-1 goes to 0; down at 0 goes to NUM_OCT-1.
- Range, WRAP=0: up at NUM_OCT-1 and down at 0 leave octave unchanged and oct_changed stays 0. The FSM still enters HOLD, so releasing and re-pressing is the only way to get a fresh edge.
- FSM (used only when REPEAT_EN=1; with REPEAT_EN=0 it stays in IDLE):
  - IDLE: on a valid single rise, take the step, latch dir (up/down), cnt=0, go to HOLD.
  - HOLD: while only the dir button is held, cnt increments. When cnt reaches HOLD_CYCLES-1, take a step in dir, cnt=0, go to REPEAT.
  - REPEAT: while only the dir button is held, cnt increments. When cnt reaches REP_CYCLES-1, take a step, cnt=0, stay in REPEAT.
  - HOLD/REPEAT exit: dir button released, or the opposite button pressed, sends the FSM to IDLE with cnt=0 and no step that cycle. An opposite-button rise arriving together with the dir release is handled as a fresh single press in that same cycle.
- Repeat steps follow the same wrap/saturate rules. In saturate mode, repeat steps at an end produce no change and no oct_changed.
- Counter width: clog2(max(HOLD_CYCLES, REP_CYCLES)+1).
- Illegal states: an octave register >= NUM_OCT (possible when NUM_OCT is not a power of 2) loads DEF_OCT on the next edge with oct_changed=1. An unused FSM encoding returns to IDLE.
- at_min and at_max are never both 1, because NUM_OCT >= 2.

Test Plan:
- Reset/default: NUM_OCT=7, DEF_OCT=3; assert rst for 2 cycles -> octave=3, oct_changed=0, at_min=0, at_max=0. Assert rst mid-REPEAT -> octave=3 on the next edge.
- Wrap: WRAP=1. From 3, four up presses (1 cycle high, 2 low each) -> 4,5,6,0, with one oct_changed pulse per press and at_min=1 after the last. Then one down press -> 6.
- Saturate: WRAP=0. At octave 6, press up -> stays 6, oct_changed=0, at_max=1. At 0, press down -> stays 0.
- Hold-repeat: REPEAT_EN=1, HOLD_CYCLES=4, REP_CYCLES=2, start at 0, hold up for 10 cycles -> steps at cycle 0 (->1), cycle 4 (->2), cycles 6, 8 (->3, 4). Release -> no further steps.
- Simultaneous: both buttons rise in the same cycle -> octave unchanged, no pulse. Hold up (REPEAT mode), then press down -> repeat stops, octave frozen, FSM=IDLE.
- Non-power-of-2 recovery: NUM_OCT=5, force octave=7 -> next edge octave=DEF_OCT, oct_changed=1.

Source files
------------

// File: rtl/oct_sel_fsm.sv
// Two-button octave selector: edge-triggered up/down stepping with optional
// hold-to-repeat, wrap or saturate at the range ends, and range flags.
module oct_sel_fsm #(
  parameter int NUM_OCT     = 7,
  parameter int DEF_OCT     = 3,
  parameter int WRAP        = 1,
  parameter int REPEAT_EN   = 0,
  parameter int HOLD_CYCLES = 16,
  parameter int REP_CYCLES  = 8,
  localparam int OW = $clog2(NUM_OCT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          octave_up,
  input  logic          octave_down,
  output logic [OW-1:0] octave,
  output logic          oct_changed,
  output logic          at_min,
  output logic          at_max
);

  localparam int MAX_CNT = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [OW-1:0] OCT_MAX   = OW'(NUM_OCT - 1);
  localparam logic [OW-1:0] OCT_DEF   = OW'(DEF_OCT);
  localparam logic [OW-1:0] OCT_ONE   = OW'(1);
  localparam logic [OW:0]   OCT_LIMIT = (OW+1)'(NUM_OCT);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] octave_q, octave_d;
  logic          oct_changed_q, oct_changed_d;
  logic          up_prev_q, up_prev_d;
  logic          down_prev_q, down_prev_d;
  logic          dir_up_q, dir_up_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic up_rise, down_rise, single_up, single_down;
  logic dir_held, press, step, step_up, octave_illegal;

  // Next octave for one step in the given direction, honouring wrap/saturate.
  function automatic logic [OW-1:0] step_target(input logic [OW-1:0] cur, input logic up);
    logic [OW-1:0] res;
    if (up) begin
      if (cur == OCT_MAX) res = (WRAP != 0) ? '0 : cur;
      else                res = cur + OCT_ONE;
    end else begin
      if (cur == '0) res = (WRAP != 0) ? OCT_MAX : cur;
      else           res = cur - OCT_ONE;
    end
    return res;
  endfunction

  // Edge detection, repeat FSM and octave update.
  always_comb begin
    up_prev_d      = octave_up;
    down_prev_d    = octave_down;
    state_d        = state_q;
    dir_up_d       = dir_up_q;
    cnt_d          = cnt_q;
    octave_d       = octave_q;
    oct_changed_d  = 1'b0;
    press          = 1'b0;
    step           = 1'b0;
    step_up        = dir_up_q;
    up_rise        = octave_up & ~up_prev_q;
    down_rise      = octave_down & ~down_prev_q;
    single_up      = up_rise & ~octave_down;
    single_down    = down_rise & ~octave_up;
    dir_held       = dir_up_q ? (octave_up & ~octave_down) : (octave_down & ~octave_up);
    octave_illegal = ({1'b0, octave_q} >= OCT_LIMIT);

    if (octave_illegal) begin
      octave_d      = OCT_DEF;
      oct_changed_d = 1'b1;
      state_d       = ST_IDLE;
      cnt_d         = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          press = single_up | single_down;
        end
        ST_HOLD, ST_REPEAT: begin
          if (dir_held) begin
            if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REP_LAST)) begin
              step    = 1'b1;
              cnt_d   = '0;
              state_d = ST_REPEAT;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            // An opposite rise coinciding with the release counts as a new press.
            press   = single_up | single_down;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (press) begin
        step     = 1'b1;
        step_up  = single_up;
        dir_up_d = single_up;
        cnt_d    = '0;
        state_d  = (REPEAT_EN != 0) ? ST_HOLD : ST_IDLE;
      end else begin
        dir_up_d = dir_up_q;
      end

      if (step) begin
        octave_d      = step_target(octave_q, step_up);
        oct_changed_d = (octave_d != octave_q);
      end else begin
        octave_d      = octave_q;
        oct_changed_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      octave_q      <= OCT_DEF;
      oct_changed_q <= 1'b0;
      up_prev_q     <= 1'b0;
      down_prev_q   <= 1'b0;
      dir_up_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      octave_q      <= octave_d;
      oct_changed_q <= oct_changed_d;
      up_prev_q     <= up_prev_d;
      down_prev_q   <= down_prev_d;
      dir_up_q      <= dir_up_d;
      cnt_q         <= cnt_d;
    end
  end

  assign octave      = octave_q;
  assign oct_changed = oct_changed_q;
  assign at_min      = (octave_q == '0);
  assign at_max      = (octave_q == OCT_MAX);

endmodule

// File: tb/tb_oct_sel_fsm.sv
// Drives four differently-parameterised selectors with shared button stimulus
// and compares each against a press-duration reference model.
module tb_oct_sel_fsm;

  localparam int P_N   [4] = '{7, 7, 7, 5};
  localparam int P_DEF [4] = '{3, 3, 3, 3};
  localparam int P_WRAP[4] = '{1, 0, 1, 0};
  localparam int P_REP [4] = '{0, 0, 1, 1};
  localparam int P_H   [4] = '{16, 16, 4, 3};
  localparam int P_R   [4] = '{8, 8, 2, 1};

  logic       clk = 1'b0;
  logic       rst, up, dn;
  logic [2:0] oct_o [4];
  logic       chg_o [4];
  logic       min_o [4];
  logic       max_o [4];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: octave, change flag, cycles since press (-1 = no press
  // being tracked) and press direction.
  int m_oct [4];
  int m_chg [4];
  int m_len [4];
  int m_dir [4];
  int pu = 0, pd = 0;
  int pulses;

  always #5 clk = ~clk;

  oct_sel_fsm #(.NUM_OCT(7), .DEF_OCT(3), .WRAP(1), .REPEAT_EN(0), .HOLD_CYCLES(16), .REP_CYCLES(8)) u0 (
    .clk(clk), .rst(rst), .octave_up(up), .octave_down(dn),
    .octave(oct_o[0]), .oct_changed(chg_o[0]), .at_min(min_o[0]), .at_max(max_o[0]));
  oct_sel_fsm #(.NUM_OCT(7), .DEF_OCT(3), .WRAP(0), .REPEAT_EN(0), .HOLD_CYCLES(16), .REP_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .octave_up(up), .octave_down(dn),
    .octave(oct_o[1]), .oct_changed(chg_o[1]), .at_min(min_o[1]), .at_max(max_o[1]));
  oct_sel_fsm #(.NUM_OCT(7), .DEF_OCT(3), .WRAP(1), .REPEAT_EN(1), .HOLD_CYCLES(4), .REP_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .octave_up(up), .octave_down(dn),
    .octave(oct_o[2]), .oct_changed(chg_o[2]), .at_min(min_o[2]), .at_max(max_o[2]));
  oct_sel_fsm #(.NUM_OCT(5), .DEF_OCT(3), .WRAP(0), .REPEAT_EN(1), .HOLD_CYCLES(3), .REP_CYCLES(1)) u3 (
    .clk(clk), .rst(rst), .octave_up(up), .octave_down(dn),
    .octave(oct_o[3]), .oct_changed(chg_o[3]), .at_min(min_o[3]), .at_max(max_o[3]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step model: a step happens on a fresh single press, and with repeat
  // enabled after HOLD cycles of holding, then every REP cycles.
  task automatic model_step();
    int ur, dr, held, move, nxt;
    ur = (up && !pu) ? 1 : 0;
    dr = (dn && !pd) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_oct[k] = P_DEF[k]; m_chg[k] = 0; m_len[k] = -1;
      end else if (m_oct[k] >= P_N[k]) begin
        m_oct[k] = P_DEF[k]; m_chg[k] = 1; m_len[k] = -1;
      end else begin
        held = (m_len[k] >= 0) && (m_dir[k] ? (up && !dn) : (dn && !up));
        move = 0;
        if (held) begin
          m_len[k]++;
          if (P_REP[k] != 0 && m_len[k] >= P_H[k] && ((m_len[k] - P_H[k]) % P_R[k]) == 0) move = 1;
        end else begin
          m_len[k] = -1;
          if ((ur && !dn) || (dr && !up)) begin
            m_dir[k] = ur; m_len[k] = 0; move = 1;
          end
        end
        nxt = m_oct[k];
        if (move) begin
          if (m_dir[k]) nxt = (m_oct[k] == P_N[k] - 1) ? (P_WRAP[k] ? 0 : m_oct[k]) : m_oct[k] + 1;
          else          nxt = (m_oct[k] == 0) ? (P_WRAP[k] ? P_N[k] - 1 : 0) : m_oct[k] - 1;
        end
        m_chg[k] = (nxt != m_oct[k]) ? 1 : 0;
        m_oct[k] = nxt;
      end
    end
    pu = rst ? 0 : int'(up);
    pd = rst ? 0 : int'(dn);
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("octave[%0d]", k), 8'(oct_o[k]), 8'(m_oct[k]));
      check($sformatf("changed[%0d]", k), 8'(chg_o[k]), 8'(m_chg[k]));
      check($sformatf("at_min[%0d]", k), 8'(min_o[k]), 8'(m_oct[k] == 0));
      check($sformatf("at_max[%0d]", k), 8'(max_o[k]), 8'(m_oct[k] == P_N[k] - 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; up = 1'b0; dn = 1'b0;
    tick(); tick();
    check("rst_octave", 8'(oct_o[0]), 8'd3);
    check("rst_changed", 8'(chg_o[0]), 8'd0);
    check("rst_at_min", 8'(min_o[0]), 8'd0);
    check("rst_at_max", 8'(max_o[0]), 8'd0);
    rst = 1'b0;

    // Four short up presses: wrap goes 4,5,6,0; saturate stops at 6.
    repeat (4) begin
      up = 1'b1; tick(); up = 1'b0; tick(); tick();
    end
    check("wrap_octave", 8'(oct_o[0]), 8'd0);
    check("wrap_at_min", 8'(min_o[0]), 8'd1);
    check("sat_top_octave", 8'(oct_o[1]), 8'd6);
    check("sat_top_at_max", 8'(max_o[1]), 8'd1);

    dn = 1'b1; tick(); dn = 1'b0; tick(); tick();
    check("wrap_down_octave", 8'(oct_o[0]), 8'd6);

    // Six down presses bring every instance to 0 (saturate holds at 0).
    repeat (6) begin
      dn = 1'b1; tick(); dn = 1'b0; tick(); tick();
    end
    check("sat_bottom_octave", 8'(oct_o[1]), 8'd0);
    check("rep_start_octave", 8'(oct_o[2]), 8'd0);

    // Hold up for 10 cycles: steps at 0, 4, 6, 8.
    pulses = 0;
    up = 1'b1;
    repeat (10) begin
      tick();
      pulses += int'(chg_o[2]);
    end
    check("repeat_octave", 8'(oct_o[2]), 8'd4);
    check("repeat_pulses", 8'(pulses), 8'd4);
    up = 1'b0;
    repeat (4) tick();
    check("release_octave", 8'(oct_o[2]), 8'd4);

    // Simultaneous rises: no step.
    up = 1'b1; dn = 1'b1; tick();
    check("both_octave", 8'(oct_o[2]), 8'd4);
    check("both_changed", 8'(chg_o[2]), 8'd0);
    up = 1'b0; dn = 1'b0; tick();

    // Into repeat, then press down: octave frozen.
    up = 1'b1;
    repeat (6) tick();
    dn = 1'b1;
    repeat (5) tick();
    check("frozen_octave", 8'(oct_o[2]), 8'd6);
    up = 1'b0; dn = 1'b0; tick();

    // Reset in the middle of a repeat.
    up = 1'b1;
    repeat (8) tick();
    rst = 1'b1; tick();
    check("mid_rst_octave", 8'(oct_o[2]), 8'd3);
    rst = 1'b0; up = 1'b0; tick();

    // Randomised button activity with occasional reset.
    repeat (400) begin
      if ($urandom_range(3) == 0) up = ~up;
      if ($urandom_range(3) == 0) dn = ~dn;
      rst = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b0; up = 1'b0; dn = 1'b0;
    tick(); tick();

    // Illegal octave on the 5-octave instance recovers to the default.
    force u3.octave_q = 3'd7;
    #1;
    release u3.octave_q;
    m_oct[3] = 7;
    tick();
    check("recover_octave", 8'(oct_o[3]), 8'd3);
    check("recover_changed", 8'(chg_o[3]), 8'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
